line_cmd_sequencer: RTL and testbench

Command-queue front end for `LineEngine`. Buffers complete line-draw commands (two endpoints plus color) from the processor-side MMIO path. Replays each command into the engine's serial load protocol: color, x0, y0, x1, then y1 with trigger. Sits directly upstream of `LineEngine`, tracks each line to completion, and counts finished lines for software polling.

---
 rtl/line_cmd_sequencer_if.sv | 24 ++
 rtl/line_cmd_sequencer.sv | 96 +++++++++
 tb/tb_line_cmd_sequencer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/line_cmd_sequencer_if.sv
// line_cmd_sequencer_if: command push port plus LineEngine serial-load port
interface line_cmd_sequencer_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [9:0]  cmd_x0, cmd_y0, cmd_x1, cmd_y1;
   logic [31:0] cmd_color;
   logic        LE_ready;
   logic [31:0] LE_color;
   logic [9:0]  LE_point;
   logic        LE_color_valid, LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid;
   logic        LE_trigger;
   logic        busy;
   logic [15:0] lines_done;
   modport master (
      output cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, LE_ready,
      input  cmd_ready, LE_color, LE_point, LE_color_valid, LE_x0_valid, LE_y0_valid,
             LE_x1_valid, LE_y1_valid, LE_trigger, busy, lines_done
   );
   modport slave (
      input  cmd_valid, cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_color, LE_ready,
      output cmd_ready, LE_color, LE_point, LE_color_valid, LE_x0_valid, LE_y0_valid,
             LE_x1_valid, LE_y1_valid, LE_trigger, busy, lines_done
   );
endinterface

// File: rtl/line_cmd_sequencer.sv
// line_cmd_sequencer: buffers line commands and replays them into LineEngine's serial load protocol
module line_cmd_sequencer #(
   parameter int DEPTH = 4,
   parameter int START_TIMEOUT = 4
) (
   input  logic clk,
   input  logic rst,
   line_cmd_sequencer_if.slave io
);
   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(START_TIMEOUT + 1);
   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_COLOR      = 3'd1;
   localparam logic [2:0] S_X0         = 3'd2;
   localparam logic [2:0] S_Y0         = 3'd3;
   localparam logic [2:0] S_X1         = 3'd4;
   localparam logic [2:0] S_Y1         = 3'd5;
   localparam logic [2:0] S_WAIT_START = 3'd6;
   localparam logic [2:0] S_WAIT_DONE  = 3'd7;
   // entry = {color[71:40], x0[39:30], y0[29:20], x1[19:10], y1[9:0]}
   logic [71:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic [39:0]   cur;
   logic [2:0]    state, state_nx;
   logic [TW-1:0] tmo;
   logic [15:0]   done_cnt;
   logic          full, push, pop, done;
   assign full = count == (AW+1)'(DEPTH);
   assign push = io.cmd_valid && !full;
   assign pop = state == S_IDLE && count != '0;
   assign done = (state == S_WAIT_START && io.LE_ready && tmo <= TW'(1)) ||
                 (state == S_WAIT_DONE && io.LE_ready);
   assign io.cmd_ready = !full;
   assign io.lines_done = done_cnt;
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= {io.cmd_color, io.cmd_x0, io.cmd_y0, io.cmd_x1, io.cmd_y1};
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:       state_nx = pop ? S_COLOR : S_IDLE;
         S_COLOR:      state_nx = io.LE_ready ? S_X0 : S_COLOR;
         S_X0:         state_nx = S_Y0;
         S_Y0:         state_nx = S_X1;
         S_X1:         state_nx = S_Y1;
         S_Y1:         state_nx = S_WAIT_START;
         S_WAIT_START: state_nx = !io.LE_ready ? S_WAIT_DONE : done ? S_IDLE : S_WAIT_START;
         S_WAIT_DONE:  state_nx = io.LE_ready ? S_IDLE : S_WAIT_DONE;
      endcase
   end
   // engine-facing outputs are registered copies decoded from the state being entered
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= S_IDLE;
         cur <= '0;
         tmo <= '0;
         done_cnt <= '0;
         io.busy <= 1'b0;
         io.LE_color <= '0;
         io.LE_point <= '0;
         io.LE_color_valid <= 1'b0;
         io.LE_x0_valid <= 1'b0;
         io.LE_y0_valid <= 1'b0;
         io.LE_x1_valid <= 1'b0;
         io.LE_y1_valid <= 1'b0;
         io.LE_trigger <= 1'b0;
      end else begin
         state <= state_nx;
         if (pop) cur <= mem[rd_ptr][39:0];
         if (pop) io.LE_color <= mem[rd_ptr][71:40];
         if (state == S_Y1) tmo <= TW'(START_TIMEOUT);
         else if (state == S_WAIT_START && tmo != '0) tmo <= tmo - 1'b1;
         if (done) done_cnt <= done_cnt + 1'b1;
         io.busy <= count != '0 || state != S_IDLE;
         io.LE_color_valid <= state_nx == S_COLOR;
         io.LE_x0_valid <= state_nx == S_X0;
         io.LE_y0_valid <= state_nx == S_Y0;
         io.LE_x1_valid <= state_nx == S_X1;
         io.LE_y1_valid <= state_nx == S_Y1;
         io.LE_trigger <= state_nx == S_Y1;
         if (state_nx == S_X0 || state_nx == S_Y0 || state_nx == S_X1 || state_nx == S_Y1)
            io.LE_point <= state_nx == S_X0 ? cur[39:30] :
                           state_nx == S_Y0 ? cur[29:20] :
                           state_nx == S_X1 ? cur[19:10] : cur[9:0];
      end
endmodule

// File: tb/tb_line_cmd_sequencer.sv
// tb_line_cmd_sequencer: random and directed line commands checked against an engine/queue model
module tb_line_cmd_sequencer;
   localparam int DEPTH = 4;
   localparam int START_TIMEOUT = 4;
   typedef struct packed {
      logic [31:0] color;
      logic [9:0]  x0, y0, x1, y1;
   } cmd_t;
   logic clk = 1'b0;
   logic rst = 1'b0;
   line_cmd_sequencer_if io();
   line_cmd_sequencer #(.DEPTH(DEPTH), .START_TIMEOUT(START_TIMEOUT)) dut (.clk(clk), .rst(rst), .io(io));
   always #5 clk = ~clk;
   int checks = 0;
   int failures = 0;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // model state: queue of accepted commands, engine behaviour and expected completion count
   cmd_t exp_q[$];
   cmd_t cur;
   int cyc = 0, stall_mode = 0, draw_mode = 3, lo_cnt = 0;
   int due = -1, lat_due = -1, gap_due = -1, idle_due = -1;
   int last_color = 0, t_x0 = 0, t_y0 = 0, t_x1 = 0, color_run = 0, run_exp = 1;
   logic [15:0] exp_done = '0, prev_done = '0;
   logic prev_color = 1'b0;
   always @(negedge clk) begin
      int nstb, d;
      cyc++;
      if (!rst) begin
         exp_q.delete();
         due = -1; lat_due = -1; gap_due = -1; idle_due = -1;
         lo_cnt = 0; exp_done = '0; prev_done = '0; prev_color = 1'b0;
         io.LE_ready = 1'b1;
      end else begin
         nstb = int'(io.LE_color_valid) + int'(io.LE_x0_valid) + int'(io.LE_y0_valid) +
                int'(io.LE_x1_valid) + int'(io.LE_y1_valid);
         if (nstb != 0) check("one_strobe", 64'(nstb), 64'd1);
         if (io.LE_trigger || io.LE_y1_valid) check("trigger_y1", 64'(io.LE_trigger), 64'(io.LE_y1_valid));
         if (io.LE_color_valid) begin
            if (!prev_color) begin
               if (exp_q.size() == 0) check("pop_nonempty", 64'd0, 64'd1);
               else cur = exp_q.pop_front();
               if (lat_due >= 0) begin
                  check("push_latency", 64'(cyc), 64'(lat_due));
                  check("busy_rise", 64'(io.busy), 64'd1);
                  lat_due = -1;
               end
               if (gap_due >= 0) begin
                  check("idle_gap", 64'(cyc), 64'(gap_due));
                  gap_due = -1;
               end
               check("color", 64'(io.LE_color), 64'(cur.color));
               color_run = 0;
               lo_cnt = stall_mode < 0 ? int'($urandom_range(0, 3)) : stall_mode;
               run_exp = lo_cnt + 1;
            end else check("color_hold_ready", 64'(io.LE_ready), 64'd0);
            color_run++;
            last_color = cyc;
         end
         if (io.LE_x0_valid) begin
            check("x0_after_ready", 64'(io.LE_ready), 64'd1);
            check("color_run", 64'(color_run), 64'(run_exp));
            check("x0_seq", 64'(cyc - last_color), 64'd1);
            check("x0", 64'(io.LE_point), 64'(cur.x0));
            t_x0 = cyc;
         end
         if (io.LE_y0_valid) begin
            check("y0_seq", 64'(cyc - t_x0), 64'd1);
            check("y0", 64'(io.LE_point), 64'(cur.y0));
            t_y0 = cyc;
         end
         if (io.LE_x1_valid) begin
            check("x1_seq", 64'(cyc - t_y0), 64'd1);
            check("x1", 64'(io.LE_point), 64'(cur.x1));
            t_x1 = cyc;
         end
         if (io.LE_y1_valid) begin
            check("y1_seq", 64'(cyc - t_x1), 64'd1);
            check("y1", 64'(io.LE_point), 64'(cur.y1));
            check("color_held", 64'(io.LE_color), 64'(cur.color));
            d = draw_mode < 0 ? int'($urandom_range(0, 8)) : draw_mode;
            if (d == 1) d = 2;
            lo_cnt = d;
            due = cyc + (d == 0 ? START_TIMEOUT + 1 : d + 1);
         end
         if (cyc == due) exp_done = exp_done + 16'd1;
         if (cyc == due || io.lines_done != prev_done) check("lines_done", 64'(io.lines_done), 64'(exp_done));
         if (cyc == due) begin
            due = -1;
            if (exp_q.size() != 0) gap_due = cyc + 1;
            else idle_due = cyc + 1;
         end
         if (cyc == idle_due) begin
            check("busy_fall", 64'(io.busy), 64'd0);
            idle_due = -1;
         end
         if (io.cmd_valid && io.cmd_ready) begin
            if (!io.busy && exp_q.size() == 0) lat_due = cyc + 2;
            exp_q.push_back(cmd_t'({io.cmd_color, io.cmd_x0, io.cmd_y0, io.cmd_x1, io.cmd_y1}));
         end
         prev_done = io.lines_done;
         prev_color = io.LE_color_valid;
         io.LE_ready = lo_cnt == 0;
         if (lo_cnt > 0) lo_cnt--;
      end
   end
   function automatic cmd_t rand_cmd();
      cmd_t c;
      c.color = $urandom();
      c.x0 = 10'($urandom());
      c.y0 = 10'($urandom());
      c.x1 = 10'($urandom());
      c.y1 = 10'($urandom());
      return c;
   endfunction
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask
   task automatic push_cmd(input cmd_t c);
      int n;
      io.cmd_valid = 1'b1;
      {io.cmd_color, io.cmd_x0, io.cmd_y0, io.cmd_x1, io.cmd_y1} = c;
      for (n = 0; n < 500 && !io.cmd_ready; n++) tick(1);
      if (n == 500) check("push_timeout", 64'd0, 64'd1);
      tick(1);
      io.cmd_valid = 1'b0;
   endtask
   task automatic wait_idle();
      int n;
      for (n = 0; n < 2000 && (io.busy || exp_q.size() != 0 || due >= 0); n++) tick(1);
      check("idle_reached", 64'(n < 2000), 64'd1);
      tick(2);
   endtask
   task automatic check_reset_outputs();
      check("rst_strobes", 64'({io.LE_color_valid, io.LE_x0_valid, io.LE_y0_valid,
                                io.LE_x1_valid, io.LE_y1_valid, io.LE_trigger}), 64'd0);
      check("rst_color", 64'(io.LE_color), 64'd0);
      check("rst_point", 64'(io.LE_point), 64'd0);
      check("rst_busy", 64'(io.busy), 64'd0);
      check("rst_lines_done", 64'(io.lines_done), 64'd0);
      check("rst_cmd_ready", 64'(io.cmd_ready), 64'd1);
   endtask
   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end
   initial begin
      int n;
      cmd_t c;
      io.cmd_valid = 1'b0;
      {io.cmd_color, io.cmd_x0, io.cmd_y0, io.cmd_x1, io.cmd_y1} = '0;
      io.LE_ready = 1'b1;
      #12;
      check_reset_outputs();
      tick(2);
      rst = 1'b1;
      tick(2);
      // single line, engine draws for 20 cycles
      stall_mode = 0;
      draw_mode = 20;
      push_cmd(cmd_t'({32'h007F0000, 10'd0, 10'd0, 10'd1023, 10'd767}));
      wait_idle();
      check("single_lines_done", 64'(io.lines_done), 64'd1);
      check("single_busy", 64'(io.busy), 64'd0);
      // engine holds ready low for 5 cycles at the color load
      stall_mode = 5;
      draw_mode = 3;
      push_cmd(rand_cmd());
      wait_idle();
      check("stall_lines_done", 64'(io.lines_done), 64'd2);
      // queue fills while a long draw blocks the engine
      stall_mode = 0;
      draw_mode = 40;
      push_cmd(rand_cmd());
      tick(10);
      draw_mode = 3;
      for (int i = 0; i < 4; i++) push_cmd(rand_cmd());
      check("full_ready_low", 64'(io.cmd_ready), 64'd0);
      io.cmd_valid = 1'b1;
      {io.cmd_color, io.cmd_x0, io.cmd_y0, io.cmd_x1, io.cmd_y1} = rand_cmd();
      tick(1);
      io.cmd_valid = 1'b0;
      check("full_still_low", 64'(io.cmd_ready), 64'd0);
      check("full_queued", 64'(exp_q.size()), 64'd4);
      wait_idle();
      check("full_lines_done", 64'(io.lines_done), 64'd7);
      // zero-length lines: engine never drops ready, timeout completes them
      draw_mode = 0;
      push_cmd(cmd_t'({32'h00123456, 10'd5, 10'd5, 10'd5, 10'd5}));
      push_cmd(rand_cmd());
      wait_idle();
      check("zero_lines_done", 64'(io.lines_done), 64'd9);
      // reset asserted during the x1 load with another command queued
      draw_mode = 3;
      push_cmd(rand_cmd());
      push_cmd(rand_cmd());
      for (n = 0; n < 50 && !io.LE_x1_valid; n++) tick(1);
      check("x1_reached", 64'(io.LE_x1_valid), 64'd1);
      rst = 1'b0;
      #1;
      check_reset_outputs();
      tick(3);
      rst = 1'b1;
      check("post_rst_ready", 64'(io.cmd_ready), 64'd1);
      tick(10);
      check("post_rst_busy", 64'(io.busy), 64'd0);
      check("post_rst_color_valid", 64'(io.LE_color_valid), 64'd0);
      // counter wrap from 16'hFFFF
      exp_done = 16'hFFFF;
      force dut.done_cnt = 16'hFFFF;
      tick(1);
      release dut.done_cnt;
      tick(2);
      check("preload", 64'(io.lines_done), 64'hFFFF);
      push_cmd(rand_cmd());
      wait_idle();
      check("wrap", 64'(io.lines_done), 64'd0);
      // random traffic: random stalls, draw lengths and timeouts
      stall_mode = -1;
      draw_mode = -1;
      for (int i = 0; i < 40; i++) begin
         push_cmd(rand_cmd());
         tick(int'($urandom_range(0, 12)));
      end
      wait_idle();
      check("random_lines_done", 64'(io.lines_done), 64'd40);
      check("random_busy", 64'(io.busy), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
